// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and one report per press
// Drives one active-low column per slot and samples synchronized rows once per slot.
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_down
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE_CNT - 1);
    localparam logic [MW-1:0] MATCH_ONE  = MW'(1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [3:0]    rs1_q;
    logic [3:0]    rs_n_q;
    logic [SW-1:0] slot_cnt_q;
    logic [SW-1:0] slot_cnt_d;
    logic [1:0]    col_idx_q;
    logic [1:0]    col_idx_d;
    logic [3:0]    col_n_q;
    logic [3:0]    col_n_d;
    logic [1:0]    row_idx_q;
    logic [MW-1:0] match_cnt_q;
    logic          key_valid_q;
    logic [3:0]    key_code_q;
    logic          key_down_q;

    logic          sample;
    logic          any_low;
    logic [1:0]    first_row;
    logic          row_hit;

    always_comb begin
        sample     = (slot_cnt_q == SLOT_LAST);
        slot_cnt_d = sample ? '0 : slot_cnt_q + SW'(1);
        col_idx_d  = col_idx_q + 2'd1;
        col_n_d    = ~(4'b0001 << col_idx_d);
        any_low    = (rs_n_q != 4'b1111);
        row_hit    = ~rs_n_q[row_idx_q];
        // Lowest-index pressed row wins when several rows are low.
        first_row  = 2'd0;
        if (!rs_n_q[0])      first_row = 2'd0;
        else if (!rs_n_q[1]) first_row = 2'd1;
        else if (!rs_n_q[2]) first_row = 2'd2;
        else if (!rs_n_q[3]) first_row = 2'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q      <= 4'b1111;
            rs_n_q     <= 4'b1111;
            slot_cnt_q <= '0;
        end else begin
            rs1_q      <= row_n;
            rs_n_q     <= rs1_q;
            slot_cnt_q <= slot_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            col_n_q     <= 4'b1110;
            row_idx_q   <= 2'd0;
            match_cnt_q <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_down_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (sample) begin
                case (state_q)
                    SCAN: begin
                        if (any_low) begin
                            row_idx_q   <= first_row;
                            match_cnt_q <= MATCH_ONE;
                            if (DEBOUNCE_CNT == 1) begin
                                key_valid_q <= 1'b1;
                                key_code_q  <= {first_row, col_idx_q};
                                key_down_q  <= 1'b1;
                                state_q     <= HELD;
                            end else begin
                                state_q <= DEBOUNCE;
                            end
                        end else begin
                            col_idx_q <= col_idx_d;
                            col_n_q   <= col_n_d;
                        end
                    end
                    DEBOUNCE: begin
                        if (row_hit) begin
                            if (match_cnt_q == MATCH_LAST) begin
                                key_valid_q <= 1'b1;
                                key_code_q  <= {row_idx_q, col_idx_q};
                                key_down_q  <= 1'b1;
                                state_q     <= HELD;
                            end else begin
                                match_cnt_q <= match_cnt_q + MATCH_ONE;
                            end
                        end else begin
                            state_q   <= SCAN;
                            col_idx_q <= col_idx_d;
                            col_n_q   <= col_n_d;
                        end
                    end
                    HELD: begin
                        if (!row_hit) begin
                            match_cnt_q <= MATCH_ONE;
                            if (DEBOUNCE_CNT == 1) begin
                                key_down_q <= 1'b0;
                                state_q    <= SCAN;
                                col_idx_q  <= col_idx_d;
                                col_n_q    <= col_n_d;
                            end else begin
                                state_q <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (!row_hit) begin
                            if (match_cnt_q == MATCH_LAST) begin
                                key_down_q <= 1'b0;
                                state_q    <= SCAN;
                                col_idx_q  <= col_idx_d;
                                col_n_q    <= col_n_d;
                            end else begin
                                match_cnt_q <= match_cnt_q + MATCH_ONE;
                            end
                        end else begin
                            state_q <= HELD;
                        end
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign col_n     = col_n_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a 4x4 matrix model
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DC  = 3;
    localparam int LAT = 3 + (DC - 1) * SD + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_down;

    logic [3:0] pressed [4];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pulse_cnt = 0;
    int         vcyc = 0;
    int         t0;
    int         exp_pulses = 0;
    logic       prev_kv = 1'b0;
    logic [3:0] sb [$];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] col_pat(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            check("kv_single", {31'd0, prev_kv}, 32'd0);
            if (sb.size() == 0) check("kv_unexpected", sb.size(), 1);
            else check("key_code", {28'd0, key_code}, {28'd0, sb.pop_front()});
            check("kd_on_valid", {31'd0, key_down}, 32'd1);
            pulse_cnt++;
            vcyc = cyc;
        end
        prev_kv = key_valid;
    end

    task automatic wait_col(input logic [3:0] target);
        int n;
        n = 0;
        while (col_n == target && n < 100) begin @(negedge clk); n++; end
        while (col_n != target && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("wait_col_timeout", {28'd0, col_n}, {28'd0, target});
    endtask

    task automatic wait_slot0();
        int n;
        n = 0;
        @(negedge clk);
        while ((cyc % SD) != 0 && n < 10) begin @(negedge clk); n++; end
    endtask

    task automatic wait_pulse();
        int n;
        n = 0;
        exp_pulses++;
        while (pulse_cnt < exp_pulses && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) check("pulse_timeout", pulse_cnt, exp_pulses);
    endtask

    task automatic wait_kd_low();
        int n;
        n = 0;
        while (key_down && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) check("kd_low_timeout", {31'd0, key_down}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"}, {28'd0, col_n}, 32'he);
        check({tag, "_kv"}, {31'd0, key_valid}, 32'd0);
        check({tag, "_code"}, {28'd0, key_code}, 32'd0);
        check({tag, "_kd"}, {31'd0, key_down}, 32'd0);
    endtask

    initial begin
        for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Idle scan: every column for SD cycles, no reports
        for (int i = 0; i < 4 * SD + 1; i++) begin
            @(negedge clk);
            check("scan_col", {28'd0, col_n}, {28'd0, col_pat((cyc / SD) % 4)});
            check("scan_kv", {31'd0, key_valid}, 32'd0);
        end
        check("scan_code", {28'd0, key_code}, 32'd0);

        // Press (2,1) aligned to the column change
        wait_col(4'b1101);
        t0 = cyc;
        pressed[2][1] = 1'b1;
        sb.push_back(4'b1001);
        wait_pulse();
        check("press_lat", vcyc - t0, LAT);
        check("held_col", {28'd0, col_n}, 32'hd);
        repeat (20) @(negedge clk);
        check("held_col_late", {28'd0, col_n}, 32'hd);
        check("held_kd", {31'd0, key_down}, 32'd1);

        wait_slot0();
        t0 = cyc;
        pressed[2][1] = 1'b0;
        wait_kd_low();
        check("release_lat", cyc - t0, LAT);
        check("release_col", {28'd0, col_n}, 32'hb);
        check("release_no_pulse", pulse_cnt, exp_pulses);

        // Press (0,3) with one bounce sample during debounce
        wait_col(4'b0111);
        pressed[0][3] = 1'b1;
        sb.push_back(4'b0011);
        repeat (4) @(negedge clk);
        pressed[0][3] = 1'b0;
        repeat (4) @(negedge clk);
        check("bounce_kd", {31'd0, key_down}, 32'd0);
        check("bounce_no_pulse", pulse_cnt, exp_pulses);
        pressed[0][3] = 1'b1;
        wait_pulse();
        check("bounce_col", {28'd0, col_n}, 32'h7);
        pressed[0][3] = 1'b0;
        wait_kd_low();

        // Two keys in column 0: second is ignored while the first is held
        wait_col(4'b1110);
        pressed[1][0] = 1'b1;
        sb.push_back(4'b0100);
        wait_pulse();
        pressed[3][0] = 1'b1;
        repeat (30) @(negedge clk);
        check("multi_kd", {31'd0, key_down}, 32'd1);
        check("multi_no_pulse", pulse_cnt, exp_pulses);
        wait_slot0();
        t0 = cyc;
        pressed[1][0] = 1'b0;
        wait_kd_low();
        check("multi_release_lat", cyc - t0, LAT);
        sb.push_back(4'b1100);
        wait_pulse();
        pressed[3][0] = 1'b0;
        wait_kd_low();

        // Reset while HELD, key stays pressed through reset
        wait_col(4'b1101);
        pressed[2][1] = 1'b1;
        sb.push_back(4'b1001);
        wait_pulse();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        sb.push_back(4'b1001);
        wait_pulse();
        check("rereport_kd", {31'd0, key_down}, 32'd1);
        pressed[2][1] = 1'b0;
        wait_kd_low();
        repeat (10) @(negedge clk);

        check("sb_empty", sb.size(), 0);
        check("pulse_total", pulse_cnt, exp_pulses);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
